buzzer_scheduler: RTL and testbench

Arbitrates sound-effect requests from up to four game-event sources onto a single buzzer output. Each request becomes a pending bit. A fixed-priority arbiter grants one pending source at a time and plays a two-note pattern for it: the base tone, a silent gap, then the tone one octave up. The block contains its own programmable half-period toggle counter, which replaces the fixed-ratio divider on the buzzer path, and it drives the board buzzer pin directly.

---
 rtl/buzzer_scheduler.sv | 149 ++++++++++++++
 tb/tb_buzzer_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_scheduler.sv
// Four-source buzzer sound-effect scheduler: fixed-priority grant,
// two-note pattern (tone, gap, tone an octave up) with its own tone divider.
module buzzer_scheduler #(
   parameter int unsigned WIDTH    = 24,
   parameter int unsigned HP0      = 95420,
   parameter int unsigned HP1      = 85034,
   parameter int unsigned HP2      = 75758,
   parameter int unsigned HP3      = 63776,
   parameter int unsigned NOTE_CYC = 5000000,
   parameter int unsigned GAP_CYC  = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       mute,
   output logic       buzzer,
   output logic       busy,
   output logic [1:0] active_id,
   output logic [3:0] pending,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, NOTE1, GAP, NOTE2} state_e;

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] HP0_W   = WIDTH'(HP0);
   localparam logic [WIDTH-1:0] HP1_W   = WIDTH'(HP1);
   localparam logic [WIDTH-1:0] HP2_W   = WIDTH'(HP2);
   localparam logic [WIDTH-1:0] HP3_W   = WIDTH'(HP3);
   localparam logic [WIDTH-1:0] NOTE_M1 = WIDTH'(NOTE_CYC - 1);
   localparam logic [WIDTH-1:0] GAP_M1  = WIDTH'(GAP_CYC - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dcnt_q, dcnt_d;
   logic [WIDTH-1:0] hcnt_q, hcnt_d;
   logic             tone_q, tone_d;
   logic             buz_q, buz_d;
   logic             done_q, done_d;
   logic [3:0]       pend_q, pend_d;
   logic [1:0]       id_q, id_d;

   logic [3:0]       clr;
   logic [1:0]       gsel;
   logic [WIDTH-1:0] hp_base, hp, hp_eff, plen_m1;
   logic             note_d;

   always_comb begin
      gsel = 2'd3;
      if (pend_q[0])      gsel = 2'd0;
      else if (pend_q[1]) gsel = 2'd1;
      else if (pend_q[2]) gsel = 2'd2;
   end

   always_comb begin
      case (id_q)
         2'd0:    hp_base = HP0_W;
         2'd1:    hp_base = HP1_W;
         2'd2:    hp_base = HP2_W;
         default: hp_base = HP3_W;
      endcase
      hp      = (state_q == NOTE2) ? (hp_base >> 1) : hp_base;
      hp_eff  = (hp == '0) ? ONE : hp;
      plen_m1 = (state_q == GAP) ? GAP_M1 : NOTE_M1;
   end

   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q + ONE;
      id_d    = id_q;
      clr     = 4'b0000;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            dcnt_d = '0;
            if (pend_q != 4'b0000) begin
               state_d = NOTE1;
               id_d    = gsel;
               clr     = 4'b0001 << gsel;
            end
         end
         NOTE1: begin
            if (dcnt_q == plen_m1) begin
               state_d = GAP;
               dcnt_d  = '0;
            end
         end
         GAP: begin
            if (dcnt_q == plen_m1) begin
               state_d = NOTE2;
               dcnt_d  = '0;
            end
         end
         NOTE2: begin
            if (dcnt_q == plen_m1) begin
               state_d = IDLE;
               dcnt_d  = '0;
               done_d  = 1'b1;
            end
         end
      endcase
      pend_d = (pend_q & ~clr) | req;
   end

   // Tone restarts from zero on every note entry; held at zero otherwise.
   always_comb begin
      note_d = (state_d == NOTE1) || (state_d == NOTE2);
      hcnt_d = '0;
      tone_d = 1'b0;
      if (note_d && (state_d == state_q)) begin
         if (hcnt_q >= hp_eff - ONE) begin
            hcnt_d = '0;
            tone_d = ~tone_q;
         end else begin
            hcnt_d = hcnt_q + ONE;
            tone_d = tone_q;
         end
      end
      buz_d = tone_q & ~mute & note_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         dcnt_q  <= '0;
         hcnt_q  <= '0;
         tone_q  <= 1'b0;
         buz_q   <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= 4'b0000;
         id_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         dcnt_q  <= dcnt_d;
         hcnt_q  <= hcnt_d;
         tone_q  <= tone_d;
         buz_q   <= buz_d;
         done_q  <= done_d;
         pend_q  <= pend_d;
         id_q    <= id_d;
      end
   end

   assign buzzer    = buz_q;
   assign busy      = (state_q != IDLE);
   assign active_id = id_q;
   assign pending   = pend_q;
   assign done      = done_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Bench for buzzer_scheduler: vector table, directed corner sequences and
// random traffic against a pattern-position reference model.
module tb_buzzer_scheduler;

   localparam int NOTE = 10;
   localparam int GAP  = 4;
   localparam int TOT  = 2 * NOTE + GAP;
   localparam int HPV [4] = '{3, 4, 5, 1};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       mute = 1'b0;
   logic       buzzer, busy, done;
   logic [1:0] active_id;
   logic [3:0] pending;

   int checks = 0;
   int errors = 0;

   buzzer_scheduler #(
      .WIDTH(24), .HP0(3), .HP1(4), .HP2(5), .HP3(1),
      .NOTE_CYC(10), .GAP_CYC(4)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .mute(mute),
      .buzzer(buzzer), .busy(busy), .active_id(active_id),
      .pending(pending), .done(done)
   );

   always #5 clk = ~clk;

   // Reference model: pattern position 0..TOT-1 while busy.
   logic [3:0] m_pend = 4'b0000;
   bit         m_busy = 0;
   logic [1:0] m_id   = 2'd0;
   int         m_pos  = 0;
   bit         m_done = 0;
   bit         m_buz  = 0;

   function automatic int tone_at(int pos, int id);
      int o, h;
      if (pos < NOTE) begin
         o = pos;
         h = HPV[id];
      end else if (pos < NOTE + GAP) begin
         return 0;
      end else begin
         o = pos - NOTE - GAP;
         h = HPV[id] >> 1;
      end
      if (h < 1) h = 1;
      return (o / h) % 2;
   endfunction

   function automatic bit in_note(int pos);
      return (pos < NOTE) || (pos >= NOTE + GAP);
   endfunction

   task automatic model_reset();
      m_pend = 4'b0000;
      m_busy = 0;
      m_id   = 2'd0;
      m_pos  = 0;
      m_done = 0;
      m_buz  = 0;
   endtask

   task automatic model_step(input logic r, input logic [3:0] q,
                             input logic m);
      bit ob;
      int op;
      logic [3:0] clr;
      if (r) begin
         model_reset();
         return;
      end
      ob = m_busy;
      op = m_pos;
      clr = 4'b0000;
      m_done = 0;
      if (!m_busy) begin
         if (m_pend != 4'b0000) begin
            for (int i = 3; i >= 0; i--)
               if (m_pend[i]) m_id = 2'(i);
            clr[m_id] = 1'b1;
            m_busy = 1;
            m_pos = 0;
         end
      end else if (m_pos == TOT - 1) begin
         m_busy = 0;
         m_done = 1;
         m_pos = 0;
      end else begin
         m_pos++;
      end
      m_pend = (m_pend & ~clr) | q;
      m_buz = 0;
      if (m_busy && ob && in_note(m_pos) && !m)
         m_buz = (tone_at(op, int'(m_id)) == 1);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Observation of DUT activity for the directed sequences.
   int cyc = 0;
   int done_cyc = -1;
   int t_rise = -1;
   int busy_cnt = 0;
   int done_cnt = 0;
   int buz_cnt = 0;
   bit prev_busy = 0;
   int grants[$];
   int gaps[$];

   task automatic clr_obs();
      done_cyc = -1;
      t_rise = -1;
      busy_cnt = 0;
      done_cnt = 0;
      buz_cnt = 0;
      grants.delete();
      gaps.delete();
   endtask

   task automatic cycle(input logic r, input logic [3:0] q,
                        input logic m);
      rst = r;
      req = q;
      mute = m;
      @(posedge clk);
      model_step(r, q, m);
      #1;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("active_id", 32'(active_id), 32'(m_id));
      chk("done", 32'(done), 32'(m_done));
      chk("buzzer", 32'(buzzer), 32'(m_buz));
      if (busy && !prev_busy) begin
         grants.push_back(int'(active_id));
         t_rise = cyc;
         if (done_cyc >= 0) gaps.push_back(cyc - done_cyc);
      end
      if (done) begin
         done_cyc = cyc;
         done_cnt++;
      end
      if (busy) busy_cnt++;
      if (buzzer) buz_cnt++;
      prev_busy = busy;
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic m);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'b0000, m);
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       mute;
      logic       busy;
      logic [3:0] pend;
      logic [1:0] id;
      logic       done;
   } vec_t;

   vec_t tbl[6];
   int p;
   bit reached;

   initial begin
      tbl[0] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};
      tbl[1] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b0};
      tbl[2] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0};
      tbl[3] = '{1'b0, 4'b1000, 1'b0, 1'b1, 4'b1000, 2'd0, 1'b0};
      tbl[4] = '{1'b0, 4'b0100, 1'b1, 1'b1, 4'b1100, 2'd0, 1'b0};
      tbl[5] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0};

      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         cycle(tbl[i].rst, tbl[i].req, tbl[i].mute);
         chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
         chk("tbl_pend", 32'(pending), 32'(tbl[i].pend));
         chk("tbl_id", 32'(active_id), 32'(tbl[i].id));
         chk("tbl_done", 32'(done), 32'(tbl[i].done));
      end

      // Single request: latency, length, one done.
      clr_obs();
      p = cyc;
      cycle(1'b0, 4'b0001, 1'b0);
      idle(30, 1'b0);
      chk("a_rise", 32'(t_rise - p), 32'd1);
      chk("a_busy_len", 32'(busy_cnt), 32'(TOT));
      chk("a_done_cnt", 32'(done_cnt), 32'd1);
      chk("a_id", 32'(grants[0]), 32'd0);

      // Simultaneous requests: priority order, one idle cycle between.
      clr_obs();
      cycle(1'b0, 4'b1010, 1'b0);
      idle(60, 1'b0);
      chk("b_ngrant", 32'(grants.size()), 32'd2);
      chk("b_first", 32'(grants[0]), 32'd1);
      chk("b_second", 32'(grants[1]), 32'd3);
      chk("b_gap", 32'(gaps[0]), 32'd1);

      // No preemption of a lower-priority pattern.
      clr_obs();
      cycle(1'b0, 4'b1000, 1'b0);
      idle(5, 1'b0);
      cycle(1'b0, 4'b0100, 1'b0);
      idle(60, 1'b0);
      chk("c_first", 32'(grants[0]), 32'd3);
      chk("c_second", 32'(grants[1]), 32'd2);

      // Request on own grant edge replays the source.
      clr_obs();
      cycle(1'b0, 4'b0010, 1'b0);
      cycle(1'b0, 4'b0010, 1'b0);
      idle(60, 1'b0);
      chk("d_ngrant", 32'(grants.size()), 32'd2);
      chk("d_first", 32'(grants[0]), 32'd1);
      chk("d_second", 32'(grants[1]), 32'd1);
      chk("d_gap", 32'(gaps[0]), 32'd1);

      // Mute for a whole pattern, then release mid-NOTE1.
      clr_obs();
      cycle(1'b0, 4'b0001, 1'b1);
      idle(30, 1'b1);
      chk("e_buz_cnt", 32'(buz_cnt), 32'd0);
      chk("e_busy_len", 32'(busy_cnt), 32'(TOT));
      chk("e_done_cnt", 32'(done_cnt), 32'd1);
      cycle(1'b0, 4'b0001, 1'b1);
      idle(6, 1'b1);
      idle(30, 1'b0);

      // Async reset mid-GAP discards pending work.
      cycle(1'b0, 4'b0001, 1'b0);
      cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0100, 1'b0);
      reached = 0;
      for (int i = 0; i < 40 && !reached; i++) begin
         if (m_busy && m_pos == NOTE + 1) reached = 1;
         else cycle(1'b0, 4'b0000, 1'b0);
      end
      chk("f_reach_gap", 32'(reached), 32'd1);
      chk("f_pend_pre", 32'(pending), 32'b0100);
      rst = 1'b1;
      #1;
      model_reset();
      chk("f_busy_async", 32'(busy), 32'd0);
      chk("f_pend_async", 32'(pending), 32'd0);
      chk("f_id_async", 32'(active_id), 32'd0);
      chk("f_buz_async", 32'(buzzer), 32'd0);
      chk("f_done_async", 32'(done), 32'd0);
      @(negedge clk);
      cycle(1'b1, 4'b0000, 1'b0);
      clr_obs();
      idle(30, 1'b0);
      chk("f_no_replay", 32'(busy_cnt), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic       r, m;
         logic [3:0] q;
         r = ($urandom_range(0, 499) == 0);
         m = ($urandom_range(0, 3) == 0);
         q = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
         cycle(r, q, m);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
